noc_output_arbiter: RTL and testbench



---
 rtl/noc_output_arbiter.sv | 153 +++++++++++++++
 tb/tb_noc_output_arbiter.sv | 261 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/noc_output_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : noc_output_arbiter
// Purpose  : Per-output-port arbiter for a 5-port NoC router. Picks one
//            requesting input (rotating priority), drives the one-hot crossbar
//            select and runs the RTS/DCTS handshake to the downstream router.
//            Define ARBITER_STRICT_RR_EN for strict round-robin (owner last).
// Revision : 1.0  initial release
// ============================================================================
module noc_output_arbiter (
    input  logic       clk,
    input  logic       rst,
    input  logic       Req_N,
    input  logic       Req_E,
    input  logic       Req_W,
    input  logic       Req_S,
    input  logic       Req_L,
    input  logic       DCTS,
    output logic       Grant_N,
    output logic       Grant_E,
    output logic       Grant_W,
    output logic       Grant_S,
    output logic       Grant_L,
    output logic [4:0] Xbar_sel,
    output logic       RTS
);

    typedef enum logic [5:0] {
        ST_IDLE = 6'b000001,
        ST_L    = 6'b000010,
        ST_N    = 6'b000100,
        ST_E    = 6'b001000,
        ST_W    = 6'b010000,
        ST_S    = 6'b100000
    } state_t;

    // Port index used by the scan: N=0, E=1, W=2, S=3, L=4 (matches Xbar_sel bits)
    localparam logic [2:0] P_N = 3'd0;
    localparam logic [2:0] P_E = 3'd1;
    localparam logic [2:0] P_W = 3'd2;
    localparam logic [2:0] P_S = 3'd3;
    localparam logic [2:0] P_L = 3'd4;

    state_t     state;
    state_t     state_in;
    logic       RTS_FF;
    logic       RTS_FF_in;

    logic [4:0] req;
    logic [2:0] scan_start;
    logic [3:0] scan_idx;
    logic       found;
    logic [2:0] pick;
    logic [4:0] grant_vec;

    assign req = {Req_L, Req_S, Req_W, Req_E, Req_N};

    function automatic state_t idx_to_state(input logic [2:0] idx);
        case (idx)
            P_N:     idx_to_state = ST_N;
            P_E:     idx_to_state = ST_E;
            P_W:     idx_to_state = ST_W;
            P_S:     idx_to_state = ST_S;
            P_L:     idx_to_state = ST_L;
            default: idx_to_state = ST_IDLE;
        endcase
    endfunction

    // First port examined by the scan; non-one-hot states fall back to IDLE order
    always_comb begin
        scan_start = P_N;
        case (state)
`ifdef ARBITER_STRICT_RR_EN
            ST_N:    scan_start = P_E;
            ST_E:    scan_start = P_W;
            ST_W:    scan_start = P_S;
            ST_S:    scan_start = P_L;
            ST_L:    scan_start = P_N;
`else
            ST_N:    scan_start = P_N;
            ST_E:    scan_start = P_E;
            ST_W:    scan_start = P_W;
            ST_S:    scan_start = P_S;
            ST_L:    scan_start = P_L;
`endif
            default: scan_start = P_N;
        endcase
    end

    always_comb begin
        found    = 1'b0;
        pick     = P_N;
        scan_idx = 4'd0;
        for (int k = 0; k < 5; k++) begin
            scan_idx = {1'b0, scan_start} + 4'(k);
            if (scan_idx >= 4'd5) begin
                scan_idx = scan_idx - 4'd5;
            end
            if (!found && req[scan_idx[2:0]]) begin
                found = 1'b1;
                pick  = scan_idx[2:0];
            end
        end
    end

    always_comb begin
        state_in  = state;
        RTS_FF_in = RTS_FF;
        if (RTS_FF && !DCTS) begin
            // Pending flit waits for downstream; owner and RTS are frozen
            state_in  = state;
            RTS_FF_in = 1'b1;
        end else if (found) begin
            state_in  = idx_to_state(pick);
            RTS_FF_in = 1'b1;
        end else begin
            state_in  = ST_IDLE;
            RTS_FF_in = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state  <= ST_IDLE;
            RTS_FF <= 1'b0;
        end else begin
            state  <= state_in;
            RTS_FF <= RTS_FF_in;
        end
    end

    always_comb begin
        Xbar_sel = 5'b00000;
        case (state)
            ST_N:    Xbar_sel = 5'b00001;
            ST_E:    Xbar_sel = 5'b00010;
            ST_W:    Xbar_sel = 5'b00100;
            ST_S:    Xbar_sel = 5'b01000;
            ST_L:    Xbar_sel = 5'b10000;
            default: Xbar_sel = 5'b00000;
        endcase
    end

    assign RTS       = RTS_FF;
    assign grant_vec = Xbar_sel & {5{RTS_FF & DCTS}};
    assign Grant_N   = grant_vec[0];
    assign Grant_E   = grant_vec[1];
    assign Grant_W   = grant_vec[2];
    assign Grant_S   = grant_vec[3];
    assign Grant_L   = grant_vec[4];

endmodule
`default_nettype wire

// File: tb/tb_noc_output_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_noc_output_arbiter
// Purpose  : Self-checking bench: directed scenarios with literal expectations
//            plus randomized traffic compared against a priority-table model.
// Revision : 1.0  initial release
// ============================================================================
module tb_noc_output_arbiter;

    logic       clk;
    logic       rst;
    logic       Req_N, Req_E, Req_W, Req_S, Req_L;
    logic       DCTS;
    logic       Grant_N, Grant_E, Grant_W, Grant_S, Grant_L;
    logic [4:0] Xbar_sel;
    logic       RTS;

    int checks = 0;
    int errors = 0;

    // Model: owner -1 = IDLE, 0..4 = N,E,W,S,L
    int m_owner = -1;
    bit m_rts   = 1'b0;
    int order [6][5];
    logic [5:0] enc [6];

    noc_output_arbiter dut (
        .clk     (clk),
        .rst     (rst),
        .Req_N   (Req_N),
        .Req_E   (Req_E),
        .Req_W   (Req_W),
        .Req_S   (Req_S),
        .Req_L   (Req_L),
        .DCTS    (DCTS),
        .Grant_N (Grant_N),
        .Grant_E (Grant_E),
        .Grant_W (Grant_W),
        .Grant_S (Grant_S),
        .Grant_L (Grant_L),
        .Xbar_sel(Xbar_sel),
        .RTS     (RTS)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
`ifdef ARBITER_STRICT_RR_EN
        order[0] = '{1, 2, 3, 4, 0};
        order[1] = '{2, 3, 4, 0, 1};
        order[2] = '{3, 4, 0, 1, 2};
        order[3] = '{4, 0, 1, 2, 3};
        order[4] = '{0, 1, 2, 3, 4};
`else
        order[0] = '{0, 1, 2, 3, 4};
        order[1] = '{1, 2, 3, 4, 0};
        order[2] = '{2, 3, 4, 0, 1};
        order[3] = '{3, 4, 0, 1, 2};
        order[4] = '{4, 0, 1, 2, 3};
`endif
        order[5] = '{0, 1, 2, 3, 4};
        enc[0] = 6'b000100;
        enc[1] = 6'b001000;
        enc[2] = 6'b010000;
        enc[3] = 6'b100000;
        enc[4] = 6'b000010;
        enc[5] = 6'b000001;
    end

    task automatic chk(input string name, input logic [5:0] act, input logic [5:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%b required=%b at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [4:0] grants();
        return {Grant_L, Grant_S, Grant_W, Grant_E, Grant_N};
    endfunction

    function automatic logic [5:0] dut_state();
        logic [5:0] s;
        s = dut.state;
        return s;
    endfunction

    task automatic setreq(input logic [4:0] v);
        {Req_L, Req_S, Req_W, Req_E, Req_N} = v;
    endtask

    task automatic cyc();
        @(posedge clk);
        #2;
    endtask

    // Model advance on each rising edge
    always @(posedge clk) begin
        logic [4:0] rv;
        int row;
        int nxt;
        rv = {Req_L, Req_S, Req_W, Req_E, Req_N};
        if (!rst) begin
            m_owner = -1;
            m_rts   = 1'b0;
        end else if (!(m_rts && !DCTS)) begin
            row = (m_owner < 0) ? 5 : m_owner;
            nxt = -1;
            for (int k = 0; k < 5; k++) begin
                if (nxt < 0 && rv[order[row][k]]) nxt = order[row][k];
            end
            m_owner = nxt;
            m_rts   = (nxt >= 0);
        end
    end

    // Cycle-by-cycle comparison against the model, mid-cycle
    always @(negedge clk) begin
        logic [4:0] exp_x;
        logic [4:0] exp_g;
        if (!rst) begin
            m_owner = -1;
            m_rts   = 1'b0;
        end
        exp_x = (m_owner >= 0) ? (5'b00001 << m_owner) : 5'b00000;
        exp_g = exp_x & {5{m_rts & DCTS}};
        chk("cmp_xbar",  {1'b0, Xbar_sel}, {1'b0, exp_x});
        chk("cmp_grant", {1'b0, grants()}, {1'b0, exp_g});
        chk("cmp_rts",   {5'b0, RTS},      {5'b0, m_rts});
        chk("cmp_state", dut_state(),      enc[(m_owner < 0) ? 5 : m_owner]);
    end

    initial begin
        rst  = 1'b0;
        DCTS = 1'b0;
        setreq(5'b00000);

        // Reset held with random inputs
        repeat (3) begin
            setreq(5'($urandom_range(0, 31)));
            DCTS = 1'($urandom_range(0, 1));
            cyc();
            chk("rst_grant", {1'b0, grants()},  6'b000000);
            chk("rst_xbar",  {1'b0, Xbar_sel},  6'b000000);
            chk("rst_rts",   {5'b0, RTS},       6'b000000);
            chk("rst_state", dut_state(),       6'b000001);
        end

        // Single East request
        rst  = 1'b1;
        setreq(5'b00010);
        DCTS = 1'b1;
        cyc();
        chk("e_state", dut_state(),      6'b001000);
        chk("e_xbar",  {1'b0, Xbar_sel}, 6'b000010);
        chk("e_rts",   {5'b0, RTS},      6'b000001);
        chk("e_grant", {1'b0, grants()}, 6'b000010);
        setreq(5'b00000);
        cyc();
        chk("e_idle_state", dut_state(), 6'b000001);
        chk("e_idle_rts",   {5'b0, RTS}, 6'b000000);

        // North and Local together from IDLE
        setreq(5'b10001);
        cyc();
        chk("nl_first", {1'b0, Xbar_sel}, 6'b000001);
        cyc();
`ifdef ARBITER_STRICT_RR_EN
        chk("nl_second", {1'b0, Xbar_sel}, 6'b010000);
`else
        chk("nl_second", {1'b0, Xbar_sel}, 6'b000001);
`endif
        cyc();
        chk("nl_third", {1'b0, Xbar_sel}, 6'b000001);
        setreq(5'b00000);
        cyc();

        // Owner S stalled by DCTS=0, request moves to N
        setreq(5'b01000);
        DCTS = 1'b0;
        cyc();
        chk("s_own", dut_state(), 6'b100000);
        setreq(5'b00001);
        repeat (3) begin
            cyc();
            chk("s_hold_state", dut_state(),      6'b100000);
            chk("s_hold_grant", {5'b0, Grant_S},  6'b000000);
            chk("s_hold_rts",   {5'b0, RTS},      6'b000001);
        end
        DCTS = 1'b1;
        #1;
        chk("s_release_grant", {5'b0, Grant_S}, 6'b000001);
        cyc();
        chk("s_to_n", dut_state(), 6'b000100);
        setreq(5'b00000);
        cyc();

        // All five requests starting from W
        setreq(5'b00100);
        cyc();
        chk("w_own", dut_state(), 6'b010000);
        setreq(5'b11111);
        cyc();
`ifdef ARBITER_STRICT_RR_EN
        chk("all_from_w", dut_state(), 6'b100000);
`else
        chk("all_from_w", dut_state(), 6'b010000);
`endif
        setreq(5'b11011);
        cyc();
`ifdef ARBITER_STRICT_RR_EN
        chk("drop_w", dut_state(), 6'b000010);
`else
        chk("drop_w", dut_state(), 6'b100000);
`endif
        setreq(5'b10011);
        cyc();
`ifdef ARBITER_STRICT_RR_EN
        chk("drop_s", dut_state(), 6'b000100);
`else
        chk("drop_s", dut_state(), 6'b000010);
`endif
        setreq(5'b00000);
        cyc();

        // Asynchronous reset while Local is being granted
        setreq(5'b10000);
        cyc();
        chk("l_grant", {5'b0, Grant_L}, 6'b000001);
        #1;
        rst = 1'b0;
        #1;
        chk("async_grant_l", {5'b0, Grant_L}, 6'b000000);
        chk("async_rts",     {5'b0, RTS},     6'b000000);
        cyc();
        rst = 1'b1;
        chk("rel_rts_low", {5'b0, RTS}, 6'b000000);
        cyc();
        chk("rel_rts_high", {5'b0, RTS},  6'b000001);
        chk("rel_state",    dut_state(),  6'b000010);

        // Randomized traffic with occasional resets
        repeat (3000) begin
            cyc();
            rst = ($urandom_range(0, 99) != 0);
            if ($urandom_range(0, 3) == 0) begin
                setreq(5'b00001 << $urandom_range(0, 4));
            end else begin
                setreq(5'($urandom_range(0, 31)));
            end
            DCTS = ($urandom_range(0, 2) != 0);
        end
        cyc();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
